// File: rtl/mem_access_unit_if.sv
// Request/response handshake and data-RAM port bundle for mem_access_unit.
// The slave modport is the access unit; master is the CPU side plus the RAM.
interface mem_access_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [4:0]  mem_addr;
    logic [3:0]  mem_wen;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_wr, req_size, req_signed, req_addr, req_wdata,
        output req_ready,
        output resp_valid, resp_rdata, resp_err,
        input  resp_ready,
        output mem_addr, mem_wen, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output req_valid, req_wr, req_size, req_signed, req_addr, req_wdata,
        input  req_ready,
        input  resp_valid, resp_rdata, resp_err,
        output resp_ready,
        input  mem_addr, mem_wen, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store controller for a 32x32 byte-enabled data RAM: one request at a time,
// lane steering for stores, extension for loads, error flagging without RAM access.
module mem_access_unit (
    input  logic               clk,
    input  logic               resetn,
    mem_access_unit_if.slave   bus,
    output logic [15:0]        load_cnt,
    output logic [15:0]        store_cnt,
    output logic [15:0]        err_cnt
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state, state_nxt;
    logic        wr_q;
    logic        signed_q;
    logic [1:0]  size_q;
    logic [1:0]  addr_lo_q;
    logic        req_err;
    logic [3:0]  wen_mask;
    logic [31:0] lane_shift;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] load_data;

    assign req_err = (bus.req_size == 2'b11)
                   | (bus.req_size == 2'b01 && bus.req_addr[0])
                   | (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00)
                   | (bus.req_addr[31:7] != 25'd0);

    always_ff @(posedge clk) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.req_valid) state_nxt = req_err ? RESP : ACCESS;
            ACCESS:  state_nxt = RESP;
            RESP:    if (bus.resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.req_ready = (state == IDLE);

    always_comb begin
        wen_mask = '0;
        case (size_q)
            2'b00:   wen_mask = 4'b0001 << addr_lo_q;
            2'b01:   wen_mask = addr_lo_q[1] ? 4'b1100 : 4'b0011;
            2'b10:   wen_mask = 4'b1111;
            default: wen_mask = '0;
        endcase
    end

    // Gated by resetn so a store caught by reset in ACCESS never commits.
    assign bus.mem_wen = (state == ACCESS && wr_q && resetn) ? wen_mask : '0;

    always_comb begin
        lane_shift = bus.mem_rdata >> {addr_lo_q, 3'b000};
        lane_b     = lane_shift[7:0];
        lane_h     = addr_lo_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        case (size_q)
            2'b00:   load_data = {{24{signed_q & lane_b[7]}}, lane_b};
            2'b01:   load_data = {{16{signed_q & lane_h[15]}}, lane_h};
            default: load_data = bus.mem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            bus.resp_valid <= 1'b0;
            bus.resp_rdata <= '0;
            bus.resp_err   <= 1'b0;
            bus.mem_addr   <= '0;
            bus.mem_wdata  <= '0;
            wr_q           <= 1'b0;
            signed_q       <= 1'b0;
            size_q         <= '0;
            addr_lo_q      <= '0;
            load_cnt       <= '0;
            store_cnt      <= '0;
            err_cnt        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        wr_q      <= bus.req_wr;
                        signed_q  <= bus.req_signed;
                        size_q    <= bus.req_size;
                        addr_lo_q <= bus.req_addr[1:0];
                        if (req_err) begin
                            bus.resp_err   <= 1'b1;
                            bus.resp_rdata <= '0;
                            bus.resp_valid <= 1'b1;
                        end else begin
                            bus.resp_err <= 1'b0;
                            bus.mem_addr <= bus.req_addr[6:2];
                            if (bus.req_wr) begin
                                case (bus.req_size)
                                    2'b00:   bus.mem_wdata <= {4{bus.req_wdata[7:0]}};
                                    2'b01:   bus.mem_wdata <= {2{bus.req_wdata[15:0]}};
                                    default: bus.mem_wdata <= bus.req_wdata;
                                endcase
                            end
                        end
                    end
                end
                ACCESS: begin
                    bus.resp_rdata <= wr_q ? '0 : load_data;
                    bus.resp_valid <= 1'b1;
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        bus.resp_valid <= 1'b0;
                        if (bus.resp_err) begin
                            if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
                        end else if (wr_q) begin
                            if (store_cnt != 16'hFFFF) store_cnt <= store_cnt + 16'd1;
                        end else begin
                            if (load_cnt != 16'hFFFF) load_cnt <= load_cnt + 16'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural data RAM and a response scoreboard.
module tb_mem_access_unit;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [15:0] load_cnt, store_cnt, err_cnt;

    always #5 clk = ~clk;

    mem_access_unit_if bus();

    mem_access_unit dut (
        .clk       (clk),
        .resetn    (resetn),
        .bus       (bus),
        .load_cnt  (load_cnt),
        .store_cnt (store_cnt),
        .err_cnt   (err_cnt)
    );

    logic [31:0] ram [32] = '{default: 32'h0};

    always @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (bus.mem_wen[b]) ram[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
    end
    assign bus.mem_rdata = ram[bus.mem_addr];

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb_q[$];
    int   passed = 0;
    int   total  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    endtask

    task automatic transact(input string tag, input logic wr, input logic [1:0] size,
                            input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] exp_rdata, input logic exp_err,
                            input logic [3:0] exp_wen, input logic [4:0] exp_maddr,
                            input logic [31:0] exp_mwdata, input int hold);
        exp_t       e;
        logic [3:0] wen_seen;
        int         lat;
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_wr     = wr;
        bus.req_size   = size;
        bus.req_signed = sgn;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        sb_q.push_back(e);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        wen_seen = '0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            wen_seen |= bus.mem_wen;
            if (lat == 1) begin
                check({tag, "_req_ready_busy"}, 32'(bus.req_ready), 32'd0);
                if (exp_wen != 4'd0) begin
                    check({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'(exp_maddr));
                    check({tag, "_mem_wdata"}, bus.mem_wdata, exp_mwdata);
                end
            end
        end while (!bus.resp_valid && lat < 8);
        check({tag, "_latency"}, lat, exp_err ? 32'd1 : 32'd2);
        check({tag, "_mem_wen"}, 32'(wen_seen), 32'(exp_wen));
        if (sb_q.size() == 0) begin
            total++;
            $error("FAIL %s_scoreboard: observed empty queue expected entry", tag);
        end else begin
            e = sb_q.pop_front();
            check({tag, "_rdata"}, bus.resp_rdata, e.rdata);
            check({tag, "_err"}, 32'(bus.resp_err), 32'(e.err));
        end
        for (int i = 0; i < hold; i++) begin
            bus.req_valid = 1'b1;
            bus.req_wr    = 1'b1;
            bus.req_size  = 2'b10;
            bus.req_addr  = 32'h20;
            bus.req_wdata = 32'h1111_1111;
            @(negedge clk);
            check({tag, "_hold_valid"}, 32'(bus.resp_valid), 32'd1);
            check({tag, "_hold_rdata"}, bus.resp_rdata, exp_rdata);
            check({tag, "_hold_ready"}, 32'(bus.req_ready), 32'd0);
            check({tag, "_hold_wen"}, 32'(bus.mem_wen), 32'd0);
        end
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1 bus.resp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_wr     = 1'b0;
        bus.req_size   = 2'b00;
        bus.req_signed = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) resetn = 1'b1;
        @(negedge clk);
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_resp_rdata", bus.resp_rdata, 32'd0);
        check("rst_resp_err", 32'(bus.resp_err), 32'd0);
        check("rst_mem_wen", 32'(bus.mem_wen), 32'd0);
        check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        check("rst_mem_wdata", bus.mem_wdata, 32'd0);
        check("rst_cnt", {err_cnt, store_cnt | load_cnt}, 32'd0);

        transact("sw10", 1, 2'b10, 0, 32'h10, 32'hDEAD_BEEF, 32'h0, 0, 4'b1111, 5'd4, 32'hDEAD_BEEF, 0);
        transact("lw10", 0, 2'b10, 0, 32'h10, 32'h0, 32'hDEAD_BEEF, 0, 4'b0000, 5'd0, 32'h0, 0);
        check("cnt_store_1", 32'(store_cnt), 32'd1);
        check("cnt_load_1", 32'(load_cnt), 32'd1);

        transact("sb13", 1, 2'b00, 0, 32'h13, 32'h0000_00A5, 32'h0, 0, 4'b1000, 5'd4, 32'hA5A5_A5A5, 0);
        transact("lbs13", 0, 2'b00, 1, 32'h13, 32'h0, 32'hFFFF_FFA5, 0, 4'b0000, 5'd0, 32'h0, 0);
        transact("lbu13", 0, 2'b00, 0, 32'h13, 32'h0, 32'h0000_00A5, 0, 4'b0000, 5'd0, 32'h0, 0);
        transact("lw10b", 0, 2'b10, 0, 32'h10, 32'h0, 32'hA5AD_BEEF, 0, 4'b0000, 5'd0, 32'h0, 0);
        transact("lbs12", 0, 2'b00, 1, 32'h12, 32'h0, 32'hFFFF_FFAD, 0, 4'b0000, 5'd0, 32'h0, 0);

        transact("sh22", 1, 2'b01, 0, 32'h22, 32'h0000_8001, 32'h0, 0, 4'b1100, 5'd8, 32'h8001_8001, 0);
        transact("lhs22", 0, 2'b01, 1, 32'h22, 32'h0, 32'hFFFF_8001, 0, 4'b0000, 5'd0, 32'h0, 0);
        transact("lhu22", 0, 2'b01, 0, 32'h22, 32'h0, 32'h0000_8001, 0, 4'b0000, 5'd0, 32'h0, 0);
        transact("lhs10", 0, 2'b01, 1, 32'h10, 32'h0, 32'hFFFF_BEEF, 0, 4'b0000, 5'd0, 32'h0, 0);
        check("cnt_store_3", 32'(store_cnt), 32'd3);
        check("cnt_load_8", 32'(load_cnt), 32'd8);

        transact("err_lw02", 0, 2'b10, 0, 32'h02, 32'h0, 32'h0, 1, 4'b0000, 5'd0, 32'h0, 0);
        transact("err_sh01", 1, 2'b01, 0, 32'h01, 32'hFFFF_FFFF, 32'h0, 1, 4'b0000, 5'd0, 32'h0, 0);
        transact("err_sz11", 0, 2'b11, 0, 32'h80, 32'h0, 32'h0, 1, 4'b0000, 5'd0, 32'h0, 0);
        transact("err_sw100", 1, 2'b10, 0, 32'h100, 32'hCAFE_F00D, 32'h0, 1, 4'b0000, 5'd0, 32'h0, 0);
        check("cnt_err_4", 32'(err_cnt), 32'd4);
        check("cnt_store_still_3", 32'(store_cnt), 32'd3);
        check("ram0_untouched", ram[0], 32'h0);

        transact("bp_lw10", 0, 2'b10, 0, 32'h10, 32'h0, 32'hA5AD_BEEF, 0, 4'b0000, 5'd0, 32'h0, 5);
        check("bp_ram8_unchanged", ram[8], 32'h8001_0000);
        check("bp_cnt_load_9", 32'(load_cnt), 32'd9);
        check("bp_cnt_store_3", 32'(store_cnt), 32'd3);

        // Reset lands while a word store to 0x0C sits in ACCESS.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_wr    = 1'b1;
        bus.req_size  = 2'b10;
        bus.req_addr  = 32'h0C;
        bus.req_wdata = 32'h1234_5678;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk) resetn = 1'b0;
        #1 check("rstmid_mem_wen", 32'(bus.mem_wen), 32'd0);
        @(posedge clk);
        #1 check("rstmid_ram3", ram[3], 32'h0);
        @(negedge clk) resetn = 1'b1;
        @(negedge clk);
        check("rstmid_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rstmid_req_ready", 32'(bus.req_ready), 32'd1);
        check("rstmid_cnt", {err_cnt, store_cnt | load_cnt}, 32'd0);
        check("rstmid_ram3_after", ram[3], 32'h0);

        transact("post_lw10", 0, 2'b10, 0, 32'h10, 32'h0, 32'hA5AD_BEEF, 0, 4'b0000, 5'd0, 32'h0, 0);
        check("post_cnt_load_1", 32'(load_cnt), 32'd1);
        check("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
